// File: rtl/ctrl_byte_fifo_if.sv
// ---------------------------------------------------------------------------
// ctrl_byte_fifo_if
// Byte path and status signals between the SPI byte receiver, the command
// byte FIFO and control_unit.
//   rx_byte/rx_valid      : bytes arriving from the SPI receiver
//   in_byte/in_ready/next : FIFO head handshake with control_unit
//   ctrl_idle             : control_unit sits in its READY state
//   clear_overflow        : clears the sticky overflow flag
//   fill                  : occupancy 0..DEPTH
//   overflow/underflow    : dropped byte (sticky) / pop on an empty head (pulse)
//   cmd_abort             : stalled partial command timed out (pulse)
// Modports: master = producer/consumer side, slave = FIFO.
// ---------------------------------------------------------------------------
interface ctrl_byte_fifo_if #(
    parameter int DEPTH = 16
);
    localparam int FW = $clog2(DEPTH) + 1;

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic [7:0]    in_byte;
    logic          in_ready;
    logic          next;
    logic          ctrl_idle;
    logic          clear_overflow;
    logic [FW-1:0] fill;
    logic          overflow;
    logic          underflow;
    logic          cmd_abort;

    modport master (
        output rx_byte, rx_valid, next, ctrl_idle, clear_overflow,
        input  in_byte, in_ready, fill, overflow, underflow, cmd_abort
    );

    modport slave (
        input  rx_byte, rx_valid, next, ctrl_idle, clear_overflow,
        output in_byte, in_ready, fill, overflow, underflow, cmd_abort
    );
endinterface

// File: rtl/ctrl_byte_fifo.sv
// ---------------------------------------------------------------------------
// ctrl_byte_fifo
// Buffers command bytes from the SPI byte receiver and presents them to
// control_unit as a registered first-word-fall-through head. Absorbs SPI
// bursts while control_unit stalls, flags dropped bytes and spurious pops.
//
// Ports:
//   clk    : system clock
//   reset  : synchronous, active-high
//   bus    : ctrl_byte_fifo_if.slave (see interface header for signals)
//
// Parameters:
//   DEPTH          : entries, power of two, >= 2
//   TIMEOUT_CYCLES : idle cycles mid-command before cmd_abort
//
// Optional feature, macro CTRL_BYTE_FIFO_TIMEOUT_EN:
//   defined   - a 16-bit idle counter pulses cmd_abort when a partial command
//               has stalled for TIMEOUT_CYCLES cycles with nothing buffered
//   undefined - no counter, cmd_abort is tied low
// ---------------------------------------------------------------------------
module ctrl_byte_fifo #(
    parameter int DEPTH          = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic              clk,
    input logic              reset,
    ctrl_byte_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [FW-1:0] fill_q, fill_d;
    logic          in_ready_q, in_ready_d;
    logic [7:0]    in_byte_q, in_byte_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q;
    logic          full, empty, push, pop;

    assign full       = (fill_q == FW'(DEPTH));
    assign empty      = (fill_q == '0);
    assign pop        = bus.next & in_ready_q;
    // At full a simultaneous pop frees the slot being written.
    assign push       = bus.rx_valid & (~full | pop);
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);

    always_comb begin
        fill_d = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FW'(1);
            2'b01:   fill_d = fill_q - FW'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        // Set wins over clear when both occur in one cycle.
        if (bus.rx_valid && full && !pop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    // Head register. Without a pop the head is reloaded from the read slot,
    // so a byte pushed into an empty FIFO appears one cycle after it is
    // stored. On a pop the following entry is shown at once; when the pop
    // takes the last stored byte, a byte pushed in the same cycle is
    // forwarded directly because it is not yet readable from mem_q.
    always_comb begin
        in_ready_d = in_ready_q;
        in_byte_d  = in_byte_q;
        if (pop) begin
            if (fill_q > FW'(1)) begin
                in_ready_d = 1'b1;
                in_byte_d  = mem_q[rd_ptr_nxt];
            end else if (push) begin
                in_ready_d = 1'b1;
                in_byte_d  = bus.rx_byte;
            end else begin
                in_ready_d = 1'b0;
            end
        end else if (!empty) begin
            in_ready_d = 1'b1;
            in_byte_d  = mem_q[rd_ptr_q];
        end else begin
            in_ready_d = 1'b0;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= bus.rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_q      <= '0;
            in_ready_q  <= 1'b0;
            in_byte_q   <= 8'h00;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            fill_q      <= fill_d;
            in_ready_q  <= in_ready_d;
            in_byte_q   <= in_byte_d;
            overflow_q  <= overflow_d;
            underflow_q <= bus.next & ~in_ready_q;
        end
    end

    assign bus.fill      = fill_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.in_byte   = in_byte_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

`ifdef CTRL_BYTE_FIFO_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        abort_q, abort_d;

    // Counts only while a command is in progress and the FIFO is starved;
    // with bytes buffered the stall is control_unit's own and is not timed.
    always_comb begin
        to_cnt_d = to_cnt_q;
        abort_d  = 1'b0;
        if (bus.ctrl_idle || bus.rx_valid) begin
            to_cnt_d = '0;
        end else if (empty) begin
            if (to_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                to_cnt_d = '0;
                abort_d  = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            abort_q  <= abort_d;
        end
    end

    assign bus.cmd_abort = abort_q;
`else
    logic unused_timeout;
    assign unused_timeout = bus.ctrl_idle & (TIMEOUT_CYCLES != 0);
    assign bus.cmd_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_byte_fifo.sv
// ---------------------------------------------------------------------------
// tb_ctrl_byte_fifo
// Directed bench for ctrl_byte_fifo: reset state, FWFT latency, fill to full,
// overflow set/clear, push+pop at full / fill==1 / empty, underflow, reset
// mid-burst and, when CTRL_BYTE_FIFO_TIMEOUT_EN is defined, the idle timeout.
// ---------------------------------------------------------------------------
module tb_ctrl_byte_fifo;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ctrl_byte_fifo_if #(.DEPTH(DEPTH)) bus ();

    ctrl_byte_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int abort_edge;

        reset              = 1'b1;
        bus.rx_byte        = 8'h00;
        bus.rx_valid       = 1'b0;
        bus.next           = 1'b0;
        bus.ctrl_idle      = 1'b1;
        bus.clear_overflow = 1'b0;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_in_byte", bus.in_byte, 8'h00);
        check("rst_fill", bus.fill, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_underflow", bus.underflow, 0);
        check("rst_cmd_abort", bus.cmd_abort, 0);
        reset = 1'b0;

        // T1: single byte, two-edge head latency, then pop
        bus.rx_byte = 8'hA5; bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        check("t1_fill_after_push", bus.fill, 1);
        check("t1_ready_edge1", bus.in_ready, 0);
        tick();
        check("t1_ready_edge2", bus.in_ready, 1);
        check("t1_byte_edge2", bus.in_byte, 8'hA5);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check("t1_ready_after_pop", bus.in_ready, 0);
        check("t1_fill_after_pop", bus.fill, 0);
        check("t1_no_underflow", bus.underflow, 0);

        // T2: fill to DEPTH, overflow push (with clear asserted: set wins)
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_byte = 8'(i); bus.rx_valid = 1'b1;
            tick();
        end
        check("t2_fill_full", bus.fill, DEPTH);
        check("t2_no_overflow_yet", bus.overflow, 0);
        bus.rx_byte = 8'hFF; bus.clear_overflow = 1'b1;
        tick();
        bus.rx_valid = 1'b0; bus.clear_overflow = 1'b0;
        check("t2_fill_still_full", bus.fill, DEPTH);
        check("t2_overflow_set", bus.overflow, 1);
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("t2_ready_%0d", i), bus.in_ready, 1);
            check($sformatf("t2_byte_%0d", i), bus.in_byte, i);
            bus.next = 1'b1;
            tick();
        end
        bus.next = 1'b0;
        check("t2_empty_ready", bus.in_ready, 0);
        check("t2_empty_fill", bus.fill, 0);
        check("t2_overflow_sticky", bus.overflow, 1);
        bus.clear_overflow = 1'b1;
        tick();
        bus.clear_overflow = 1'b0;
        check("t2_overflow_cleared", bus.overflow, 0);

        // T3: push+pop at full
        for (int i = 0; i < DEPTH; i++) begin
            bus.rx_byte = 8'(8'h10 + i); bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_valid = 1'b0;
        tick();
        check("t3_fill_full", bus.fill, DEPTH);
        check("t3_head", bus.in_byte, 8'h10);
        bus.rx_byte = 8'h77; bus.rx_valid = 1'b1; bus.next = 1'b1;
        tick();
        bus.rx_valid = 1'b0; bus.next = 1'b0;
        check("t3_fill_unchanged", bus.fill, DEPTH);
        check("t3_no_overflow", bus.overflow, 0);
        for (int i = 1; i < DEPTH; i++) begin
            check($sformatf("t3_byte_%0d", i), bus.in_byte, 8'h10 + i);
            bus.next = 1'b1;
            tick();
        end
        check("t3_last_ready", bus.in_ready, 1);
        check("t3_last_byte", bus.in_byte, 8'h77);
        tick();
        check("t3_last_stable", bus.in_byte, 8'h77);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check("t3_drained", bus.fill, 0);

        // T4: underflow on empty, pointers intact afterwards
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check("t4_underflow_pulse", bus.underflow, 1);
        check("t4_fill", bus.fill, 0);
        tick();
        check("t4_underflow_one_cycle", bus.underflow, 0);
        bus.rx_byte = 8'h5A; bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        check("t4_after_byte", bus.in_byte, 8'h5A);

        // push+pop at fill==1: new byte becomes head, in_ready stays high
        bus.rx_byte = 8'h02; bus.rx_valid = 1'b1; bus.next = 1'b1;
        tick();
        bus.rx_valid = 1'b0; bus.next = 1'b0;
        check("f1_ready", bus.in_ready, 1);
        check("f1_byte", bus.in_byte, 8'h02);
        check("f1_fill", bus.fill, 1);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        check("f1_drained", bus.fill, 0);

        // push+next at empty: pop invalid, push stored
        bus.rx_byte = 8'h33; bus.rx_valid = 1'b1; bus.next = 1'b1;
        tick();
        bus.rx_valid = 1'b0; bus.next = 1'b0;
        check("e_fill", bus.fill, 1);
        check("e_underflow", bus.underflow, 1);
        tick();
        check("e_byte", bus.in_byte, 8'h33);

        // T5: reset mid-burst discards contents and the reset-cycle write
        for (int i = 0; i < 8; i++) begin
            bus.rx_byte = 8'(8'h80 + i); bus.rx_valid = 1'b1;
            tick();
        end
        bus.rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.next = 1'b1;
            tick();
        end
        bus.next = 1'b0;
        check("t5_fill_before_rst", bus.fill, 6);
        reset = 1'b1; bus.rx_byte = 8'hEE; bus.rx_valid = 1'b1;
        tick();
        reset = 1'b0; bus.rx_valid = 1'b0;
        check("t5_fill_rst", bus.fill, 0);
        check("t5_ready_rst", bus.in_ready, 0);
        bus.rx_byte = 8'h3C; bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        check("t5_fill", bus.fill, 1);
        check("t5_byte", bus.in_byte, 8'h3C);
        check("t5_overflow", bus.overflow, 0);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;

`ifdef CTRL_BYTE_FIFO_TIMEOUT_EN
        // T6: abort after 100 starved cycles with control_unit busy
        bus.ctrl_idle = 1'b0;
        abort_edge = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.cmd_abort === 1'b1) begin
                abort_edge = k;
                break;
            end
        end
        check("t6_abort_edge", abort_edge, 100);
        tick();
        check("t6_abort_one_cycle", bus.cmd_abort, 0);
        for (int k = 0; k < 48; k++) tick();
        bus.rx_byte = 8'h42; bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        tick();
        check("t6_byte_kept", bus.in_byte, 8'h42);
        bus.next = 1'b1;
        tick();
        bus.next = 1'b0;
        abort_edge = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            if (bus.cmd_abort === 1'b1) begin
                abort_edge = k;
                break;
            end
        end
        check("t6_abort_after_rx", abort_edge, 100);
        bus.ctrl_idle = 1'b1;
`else
        bus.ctrl_idle = 1'b0;
        for (int k = 0; k < 120; k++) tick();
        check("t6_abort_disabled", bus.cmd_abort, 0);
        bus.ctrl_idle = 1'b1;
        abort_edge = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
